// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memresp_pkg
//  Description : Shared types and default constants for the memory responder.
//                Holds the FSM state enum, the latched operation enum and the
//                default bus width / depth / wait-state / protection constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package memresp_pkg;

    // Default geometry and timing
    localparam int c_addr_width  = 8;
    localparam int c_data_width  = 8;
    localparam int c_depth       = 256;
    localparam int c_wait_cycles = 2;
    localparam int c_prot_limit  = 64;

    // Wait-state counter width; holds WAIT_CYCLES up to 15
    localparam int c_cnt_width   = 4;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation captured at acceptance
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } op_t;

endpackage : memresp_pkg
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_if
//  Description : Request/response bundle between the processor core (master)
//                and the memory responder (slave).
//                master drives : memread, memwrite, adr, wd
//                slave drives  : rd, ready, busy, err
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if
    import memresp_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width
) ();

    logic                  memread;
    logic                  memwrite;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] rd;
    logic                  ready;
    logic                  busy;
    logic                  err;

    modport master (
        output memread,
        output memwrite,
        output adr,
        output wd,
        input  rd,
        input  ready,
        input  busy,
        input  err
    );

    modport slave (
        input  memread,
        input  memwrite,
        input  adr,
        input  wd,
        output rd,
        output ready,
        output busy,
        output err
    );

endinterface : mem_responder_if
`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Single-port byte array, synchronous write, combinational read.
//                Contents are never cleared by reset.
//  Ports       : clk      - clock
//                i_we     - write enable (sampled on rising edge)
//                i_addr   - word index
//                i_wdata  - write data
//                o_rdata  - combinational read data at i_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [AW-1:0]         i_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    output logic      [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder. Accepts a single read or write strobe
//                in IDLE, latches the request, waits WAIT_CYCLES cycles, then
//                performs the byte access and pulses ready for one cycle.
//                Both strobes at once give a standalone one-cycle err pulse;
//                out-of-range accesses complete with ready and err.
//  Ports       : clk   - clock
//                reset - synchronous active-high reset
//                bus   - mem_responder_if.slave
//                        (memread, memwrite, adr, wd in; rd, ready, busy, err out)
//  Config      : MEM_RESPONDER_WRITE_PROTECT_EN - when defined, writes below
//                PROT_LIMIT complete with ready+err and leave the array intact.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import memresp_pkg::*;
#(
    parameter int ADDR_WIDTH  = c_addr_width,
    parameter int DATA_WIDTH  = c_data_width,
    parameter int DEPTH       = c_depth,
    parameter int WAIT_CYCLES = c_wait_cycles,
    parameter int PROT_LIMIT  = c_prot_limit
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_responder_if.slave  bus
);

    localparam int                          c_aw         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]         c_depth_lim  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]         c_prot_lim   = (ADDR_WIDTH + 1)'(PROT_LIMIT);
    localparam logic [c_cnt_width-1:0]      c_wait_load  = c_cnt_width'(WAIT_CYCLES);
`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
    localparam logic                        c_prot_en    = 1'b1;
`else
    localparam logic                        c_prot_en    = 1'b0;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_cnt_width-1:0]  r_cnt;
    logic [c_cnt_width-1:0]  w_cnt_nxt;
    op_t                     r_op;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_wd;
    logic [DATA_WIDTH-1:0]   r_rd;
    logic                    r_conflict;
    logic                    w_conflict_nxt;
    logic                    w_accept;

    logic                    w_resp;
    logic                    w_in_range;
    logic                    w_prot;
    logic                    w_we;
    logic [DATA_WIDTH-1:0]   w_arr_rdata;
    logic [DATA_WIDTH-1:0]   w_rd_resp;

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_conflict_nxt = 1'b0;
        w_accept       = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.memread ^ bus.memwrite) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = c_wait_load;
                    // With no wait states the access is performed in the very
                    // next cycle.
                    w_state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end else if (bus.memread && bus.memwrite) begin
                    w_conflict_nxt = 1'b1;
                end
            end
            WAIT: begin
                // Counter is loaded with WAIT_CYCLES, so WAIT lasts exactly
                // WAIT_CYCLES cycles; leaving on 1 (or below) keeps it bounded.
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= c_cnt_width'(1)) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latch and held read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_conflict <= 1'b0;
            r_op       <= READ;
            r_adr      <= '0;
            r_wd       <= '0;
            r_rd       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_conflict <= w_conflict_nxt;
            if (w_accept) begin
                r_op  <= bus.memwrite ? WRITE : READ;
                r_adr <= bus.adr;
                r_wd  <= bus.wd;
            end
            // Capture the returned byte so rd keeps it after RESP
            if (w_resp && (r_op == READ)) begin
                r_rd <= w_rd_resp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign w_resp     = (r_state == RESP);
    assign w_in_range = ({1'b0, r_adr} < c_depth_lim);
    assign w_prot     = c_prot_en && (r_op == WRITE) && ({1'b0, r_adr} < c_prot_lim);

    // Write lands at the end of RESP; reset in that cycle discards it.
    assign w_we       = w_resp && (r_op == WRITE) && w_in_range && !w_prot && !reset;
    assign w_rd_resp  = w_in_range ? w_arr_rdata : '0;

    mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (c_aw)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_adr[c_aw-1:0]),
        .i_wdata (r_wd),
        .o_rdata (w_arr_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ready = w_resp;
    assign bus.busy  = (r_state != IDLE);
    assign bus.err   = r_conflict | (w_resp & (~w_in_range | w_prot));
    assign bus.rd    = (w_resp && (r_op == READ)) ? w_rd_resp : r_rd;

endmodule : mem_responder
`default_nettype wire
